vc_credit_gate: RTL and testbench

Per-virtual-channel request qualifier for the router output port: it ANDs each VC's request with a "downstream buffer has space" condition tracked by a per-VC credit counter. It sits between the VC request logic and the switch allocator. Only requests that can actually be sent are passed on. The counters are decremented on each flit sent and incremented on each credit returned from the downstream router.

---
 rtl/vc_router_pkg.sv | 16 +
 rtl/vc_credit_counter.sv | 51 +++++
 rtl/vc_credit_gate.sv | 71 +++++++
 tb/tb_vc_credit_gate.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vc_router_pkg.sv
// Shared router constants and elaboration helpers for the VC credit logic.
package vc_router_pkg;

  localparam int NUM_VC_DEF       = 4;
  localparam int CREDIT_DEPTH_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Saturating up/down credit counter for one virtual channel.
module vc_credit_counter
  import vc_router_pkg::*;
#(
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int CW           = clog2(CREDIT_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          zero,
  output logic          err_under,
  output logic          err_over
);

  localparam logic [CW-1:0] MaxCnt = CW'(CREDIT_DEPTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt  = cnt_q;
  assign full = (cnt_q == MaxCnt);
  assign zero = (cnt_q == '0);

  // A simultaneous send and return cancel out, so neither boundary error can fire.
  always_comb begin
    cnt_d     = cnt_q;
    err_under = 1'b0;
    err_over  = 1'b0;
    case ({inc, dec})
      2'b01: begin
        if (zero) err_under = 1'b1;
        else      cnt_d = cnt_q - CW'(1);
      end
      2'b10: begin
        if (full) err_over = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= MaxCnt;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vc_credit_gate.sv
// Qualifies per-VC requests with downstream credit availability and
// flags credit protocol violations with sticky error bits.
module vc_credit_gate
  import vc_router_pkg::*;
#(
  parameter int NUM_VC       = NUM_VC_DEF,
  parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
  parameter int VCW          = clog2(NUM_VC),
  parameter int CW           = clog2(CREDIT_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_VC-1:0]    req,
  input  logic                 send_valid,
  input  logic [VCW-1:0]       send_vc,
  input  logic [NUM_VC-1:0]    credit_ret,
  output logic [NUM_VC-1:0]    qual_req,
  output logic [NUM_VC*CW-1:0] credit_cnt,
  output logic [NUM_VC-1:0]    vc_full,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  logic [NUM_VC-1:0] zero_vec;
  logic [NUM_VC-1:0] under_vec;
  logic [NUM_VC-1:0] over_vec;
  logic              err_underflow_q;
  logic              err_underflow_d;
  logic              err_overflow_q;
  logic              err_overflow_d;

  // Out-of-range send_vc matches no lane, so such sends are silently dropped.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic dec;
    assign dec = send_valid && (send_vc == VCW'(v));

    vc_credit_counter #(
      .CREDIT_DEPTH(CREDIT_DEPTH),
      .CW          (CW)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (credit_ret[v]),
      .dec      (dec),
      .cnt      (credit_cnt[v*CW +: CW]),
      .full     (vc_full[v]),
      .zero     (zero_vec[v]),
      .err_under(under_vec[v]),
      .err_over (over_vec[v])
    );
  end

  assign qual_req = req & ~zero_vec;

  assign err_underflow_d = err_underflow_q | (|under_vec);
  assign err_overflow_d  = err_overflow_q  | (|over_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_vc_credit_gate.sv
// Directed self-checking bench for vc_credit_gate with default parameters.
module tb_vc_credit_gate;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        send_valid;
  logic [1:0]  send_vc;
  logic [3:0]  credit_ret;
  logic [3:0]  qual_req;
  logic [15:0] credit_cnt;
  logic [3:0]  vc_full;
  logic        err_underflow;
  logic        err_overflow;

  int errors = 0;
  int checks = 0;

  vc_credit_gate dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .send_valid   (send_valid),
    .send_vc      (send_vc),
    .credit_ret   (credit_ret),
    .qual_req     (qual_req),
    .credit_cnt   (credit_cnt),
    .vc_full      (vc_full),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge with the given inputs held, then settle just past it.
  task automatic applyStimulus(input logic sv, input logic [1:0] vc, input logic [3:0] cr);
    send_valid = sv;
    send_vc    = vc;
    credit_ret = cr;
    @(posedge clk);
    #1;
    send_valid = 1'b0;
    send_vc    = 2'd0;
    credit_ret = 4'd0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = 4'b1011;
    send_valid = 1'b0;
    send_vc    = 2'd0;
    credit_ret = 4'd0;
    #12;
    rst = 1'b0;
    #2;

    checkOutput("reset_cnt",   32'(credit_cnt), 32'h8888);
    checkOutput("reset_full",  32'(vc_full), 32'hF);
    checkOutput("reset_under", 32'(err_underflow), 32'd0);
    checkOutput("reset_over",  32'(err_overflow), 32'd0);
    checkOutput("reset_qual",  32'(qual_req), 32'hB);

    req = 4'b1111;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'd2, 4'd0);
    checkOutput("drain7_cnt",  32'(credit_cnt), 32'h8188);
    checkOutput("drain7_qual", 32'(qual_req), 32'hF);
    applyStimulus(1'b1, 2'd2, 4'd0);
    checkOutput("drain8_cnt",  32'(credit_cnt), 32'h8088);
    checkOutput("drain8_qual", 32'(qual_req), 32'hB);
    checkOutput("drain8_full", 32'(vc_full), 32'hB);

    applyStimulus(1'b1, 2'd2, 4'b0100);
    checkOutput("both_at0_cnt",   32'(credit_cnt), 32'h8088);
    checkOutput("both_at0_under", 32'(err_underflow), 32'd0);
    applyStimulus(1'b0, 2'd0, 4'b0100);
    checkOutput("ret_cnt",  32'(credit_cnt), 32'h8188);
    checkOutput("ret_qual", 32'(qual_req), 32'hF);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'd1, 4'd0);
    checkOutput("drain1_qual", 32'(qual_req), 32'hD);
    checkOutput("drain1_under", 32'(err_underflow), 32'd0);
    applyStimulus(1'b1, 2'd1, 4'd0);
    checkOutput("under_flag", 32'(err_underflow), 32'd1);
    checkOutput("under_cnt",  32'(credit_cnt), 32'h8108);
    checkOutput("under_noover", 32'(err_overflow), 32'd0);
    applyStimulus(1'b0, 2'd0, 4'b0001);
    checkOutput("over_flag", 32'(err_overflow), 32'd1);
    checkOutput("over_cnt",  32'(credit_cnt), 32'h8108);
    applyStimulus(1'b0, 2'd0, 4'b0010);
    checkOutput("sticky_under", 32'(err_underflow), 32'd1);
    checkOutput("sticky_over",  32'(err_overflow), 32'd1);
    checkOutput("sticky_cnt",   32'(credit_cnt), 32'h8118);

    // Walk counters to VC0..VC3 = {3,0,5,7}.
    applyStimulus(1'b1, 2'd1, 4'b0100);
    applyStimulus(1'b1, 2'd3, 4'b0100);
    applyStimulus(1'b1, 2'd0, 4'b0100);
    applyStimulus(1'b1, 2'd0, 4'b0100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 4'd0);
    checkOutput("mixed_cnt",  32'(credit_cnt), 32'h7503);
    checkOutput("mixed_qual", 32'(qual_req), 32'hD);
    applyStimulus(1'b0, 2'd0, 4'b1111);
    checkOutput("retall_cnt",  32'(credit_cnt), 32'h8614);
    checkOutput("retall_full", 32'(vc_full), 32'h8);
    checkOutput("retall_qual", 32'(qual_req), 32'hF);

    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_cnt",   32'(credit_cnt), 32'h8888);
    checkOutput("async_under", 32'(err_underflow), 32'd0);
    checkOutput("async_over",  32'(err_overflow), 32'd0);
    checkOutput("async_full",  32'(vc_full), 32'hF);
    #3;
    rst = 1'b0;
    applyStimulus(1'b1, 2'd3, 4'd0);
    checkOutput("post_rst_cnt", 32'(credit_cnt), 32'h7888);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
